data_island_packet_scheduler: RTL and testbench
===============================================

Name: data_island_packet_scheduler

Overview:
Sits between the HDMI packet sources (audio clock regeneration, audio sample, AVI InfoFrame, Audio InfoFrame) and the packet assembler in the clk_pixel domain. Each time the data island framer offers a packet slot, the block picks which packet type is sent. It tracks outstanding requests, enforces priority with an anti-starvation rule, and reports overrun/miss conditions through sticky status bits. It never touches packet payloads; it only drives the select/grant that muxes header and subpackets.

Parameters:
SAMPLE_CNT_WIDTH, 3, width of the saturating pending-audio-sample counter (max pending = 2^W-1)
AUDIO_BURST_MAX, 4, consecutive audio-sample grants allowed while an InfoFrame is pending before one InfoFrame is forced

Ports:
clk_pixel  in  1  pixel clock; only clock
reset_n  in  1  asynchronous active-low reset
packet_slot  in  1  one-cycle pulse: framer can accept the next packet
acr_toggle  in  1  ACR request toggle (clk_pixel domain); each edge = one ACR request
audio_sample_valid  in  1  one-cycle pulse: one audio sample packet ready
frame_start  in  1  one-cycle pulse at start of each video frame
clear_status  in  1  one-cycle pulse: clears all sticky status bits
packet_valid  out  1  one-cycle pulse, cycle after packet_slot
packet_type  out  8  HB0 of granted packet; held until next grant
packet_grant  out  4  one-hot, valid with packet_valid: [0]ACR [1]audio [2]AVI [3]AIF; all zero = null packet
acr_overrun  out  1  sticky: new ACR edge while ACR already pending
audio_overflow  out  1  sticky: sample pulse while counter saturated
infoframe_miss  out  1  sticky: frame_start while AVI or AIF still pending

Behaviour:
- Reset (async assert, sync deassert handled upstream): packet_valid=0, packet_type=8'h00, packet_grant=0, all status=0, acr_toggle_q=0, all pending flags/counters=0, burst counter=0.
- ACR request: edge = acr_toggle ^ acr_toggle_q (register updated every cycle). Edge sets acr_pending. Edge while acr_pending already 1 and not granted this cycle -> acr_overrun=1; pending stays 1 (one ACR queued max).
- Audio: audio_sample_valid increments sample_cnt, saturating at 2^W-1. A pulse while saturated sets audio_overflow; the count stays saturated.
- frame_start sets avi_pending and aif_pending. If either is already 1, infoframe_miss=1 and the flags stay 1.
- Arbitration on packet_slot, registered; outputs appear exactly 1 cycle later:
  - Priority: ACR > audio (sample_cnt>0) > AVI > AIF > null.
  - Override: if burst_cnt==AUDIO_BURST_MAX and (avi_pending|aif_pending), the InfoFrame is granted over audio. ACR is still higher.
  - burst_cnt increments on each audio grant made while an InfoFrame is pending (saturates at AUDIO_BURST_MAX). It clears on any non-audio grant, or when no InfoFrame is pending.
- Type codes: null 8'h00, ACR 8'h01, audio 8'h02, AVI 8'h82, AIF 8'h84.
- Grant consumes its request in the same edge that registers the grant:
  - ACR: clears acr_pending.
  - Audio: decrements sample_cnt.
  - AVI/AIF: clears the corresponding pending flag.
- Simultaneous events:
  - ACR edge coincident with ACR grant: the set wins; pending stays 1, no overrun flagged.
  - Sample pulse coincident with audio grant: count unchanged; overflow is never flagged in this case.
  - frame_start coincident with an InfoFrame grant: the granted flag ends at 1 (re-armed), no miss for that flag.
- packet_slot pulses closer than 1 cycle apart are illegal; back-to-back slots on consecutive cycles are legal and arbitrated independently.
- clear_status clears sticky bits. A status event in the same cycle as clear_status wins (bit set).
- Reset mid-operation discards all pending requests; no grant is emitted after reset assertion.

Decomposition:
- Package hdmi_packet_pkg:
  - packet type localparams (PKT_NULL, PKT_ACR, PKT_AUDIO_SAMPLE, PKT_AVI_INFOFRAME, PKT_AUDIO_INFOFRAME).
  - grant index enum (GRANT_ACR..GRANT_AIF).
- One sub-module, packet_request_tracker, holds the pending-flag and saturating-counter logic with set/consume/overflow per source. The top-level holds the arbiter, burst counter and output registers.

Test Plan:
- Reset then 3 acr_toggle edges 40 cycles apart, slot 10 cycles after each -> three grants, packet_type=8'h01, packet_grant=4'b0001, acr_overrun=0.
- 9 sample pulses with no slots (W=3) -> audio_overflow=1 on 8th pulse. Then 8 slots -> 7 audio grants (8'h02) followed by a null grant (8'h00, grant 0).
- frame_start, then 6 sample pulses, then 6 slots -> grants audio×4, AVI (8'h82), audio; next slots give audio, AIF (8'h84).
- ACR edge and audio pending, slot -> ACR first; ACR edge on same cycle as ACR grant -> next slot grants ACR again, acr_overrun=0.
- Two frame_start pulses with no slots between -> infoframe_miss=1. clear_status -> 0. clear_status coincident with a third frame_start -> stays 1.
- Assert reset_n low mid-run with all pending set -> outputs immediately 0. After release, a slot yields a null grant.

Source files
------------

// File: rtl/hdmi_packet_pkg.sv
// Shared HDMI data-island packet definitions: HB0 type codes and grant bit positions.
package hdmi_packet_pkg;

  localparam logic [7:0] PKT_NULL            = 8'h00;
  localparam logic [7:0] PKT_ACR             = 8'h01;
  localparam logic [7:0] PKT_AUDIO_SAMPLE    = 8'h02;
  localparam logic [7:0] PKT_AVI_INFOFRAME   = 8'h82;
  localparam logic [7:0] PKT_AUDIO_INFOFRAME = 8'h84;

  localparam int GRANT_W = 4;

  // Bit positions inside the one-hot packet_grant vector.
  typedef enum logic [1:0] {
    GRANT_ACR   = 2'd0,
    GRANT_AUDIO = 2'd1,
    GRANT_AVI   = 2'd2,
    GRANT_AIF   = 2'd3
  } grant_idx_e;

endpackage

// File: rtl/packet_request_tracker.sv
// Per-source outstanding-request bookkeeping: ACR flag, saturating audio count, InfoFrame flags.
module packet_request_tracker
  import hdmi_packet_pkg::*;
#(
  parameter int SAMPLE_CNT_WIDTH = 3
) (
  input  logic                        clk_pixel,
  input  logic                        reset_n,
  input  logic                        acr_toggle,
  input  logic                        audio_sample_valid,
  input  logic                        frame_start,
  input  logic [GRANT_W-1:0]          consume,
  output logic                        acr_pending,
  output logic [SAMPLE_CNT_WIDTH-1:0] sample_cnt,
  output logic                        avi_pending,
  output logic                        aif_pending,
  output logic                        acr_overrun_evt,
  output logic                        audio_overflow_evt,
  output logic                        infoframe_miss_evt
);

  localparam logic [SAMPLE_CNT_WIDTH-1:0] CNT_MAX = '1;

  logic                        acr_toggle_q;
  logic                        acr_edge;
  logic                        acr_pending_q, acr_pending_d;
  logic [SAMPLE_CNT_WIDTH-1:0] sample_cnt_q, sample_cnt_d;
  logic                        avi_pending_q, avi_pending_d;
  logic                        aif_pending_q, aif_pending_d;

  assign acr_edge = acr_toggle ^ acr_toggle_q;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    acr_pending_d      = acr_pending_q;
    sample_cnt_d       = sample_cnt_q;
    avi_pending_d      = avi_pending_q;
    aif_pending_d      = aif_pending_q;

    // A new request always beats the consume of the old one in the same cycle.
    if (acr_edge)                acr_pending_d = 1'b1;
    else if (consume[GRANT_ACR]) acr_pending_d = 1'b0;

    if (audio_sample_valid && !consume[GRANT_AUDIO]) begin
      if (sample_cnt_q != CNT_MAX) sample_cnt_d = sample_cnt_q + 1'b1;
    end else if (!audio_sample_valid && consume[GRANT_AUDIO]) begin
      sample_cnt_d = sample_cnt_q - 1'b1;
    end

    if (frame_start)             avi_pending_d = 1'b1;
    else if (consume[GRANT_AVI]) avi_pending_d = 1'b0;
    if (frame_start)             aif_pending_d = 1'b1;
    else if (consume[GRANT_AIF]) aif_pending_d = 1'b0;

    acr_overrun_evt    = acr_edge && acr_pending_q && !consume[GRANT_ACR];
    audio_overflow_evt = audio_sample_valid && !consume[GRANT_AUDIO]
                         && (sample_cnt_q == CNT_MAX);
    infoframe_miss_evt = frame_start
                         && ((avi_pending_q && !consume[GRANT_AVI])
                          || (aif_pending_q && !consume[GRANT_AIF]));
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      acr_toggle_q  <= 1'b0;
      acr_pending_q <= 1'b0;
      sample_cnt_q  <= '0;
      avi_pending_q <= 1'b0;
      aif_pending_q <= 1'b0;
    end else begin
      acr_toggle_q  <= acr_toggle;
      acr_pending_q <= acr_pending_d;
      sample_cnt_q  <= sample_cnt_d;
      avi_pending_q <= avi_pending_d;
      aif_pending_q <= aif_pending_d;
    end
  end

  assign acr_pending = acr_pending_q;
  assign sample_cnt  = sample_cnt_q;
  assign avi_pending = avi_pending_q;
  assign aif_pending = aif_pending_q;

endmodule

// File: rtl/data_island_packet_scheduler.sv
// Picks the packet type for each data-island slot: fixed priority with an audio-burst
// limit that forces a pending InfoFrame through, plus sticky overrun/miss status.
module data_island_packet_scheduler
  import hdmi_packet_pkg::*;
#(
  parameter int SAMPLE_CNT_WIDTH = 3,
  parameter int AUDIO_BURST_MAX  = 4
) (
  input  logic               clk_pixel,
  input  logic               reset_n,
  input  logic               packet_slot,
  input  logic               acr_toggle,
  input  logic               audio_sample_valid,
  input  logic               frame_start,
  input  logic               clear_status,
  output logic               packet_valid,
  output logic [7:0]         packet_type,
  output logic [GRANT_W-1:0] packet_grant,
  output logic               acr_overrun,
  output logic               audio_overflow,
  output logic               infoframe_miss
);

  localparam int                   BURST_W     = $clog2(AUDIO_BURST_MAX + 1);
  localparam logic [BURST_W-1:0]   BURST_LIMIT = BURST_W'(AUDIO_BURST_MAX);

  logic                        acr_pending, avi_pending, aif_pending;
  logic [SAMPLE_CNT_WIDTH-1:0] sample_cnt;
  logic                        acr_overrun_evt, audio_overflow_evt, infoframe_miss_evt;
  logic                        if_pending, force_if;
  logic [GRANT_W-1:0]          grant_sel, consume;
  logic [7:0]                  type_sel;
  logic [BURST_W-1:0]          burst_q, burst_d;

  logic                        packet_valid_q;
  logic [7:0]                  packet_type_q;
  logic [GRANT_W-1:0]          packet_grant_q;
  logic                        acr_overrun_q, audio_overflow_q, infoframe_miss_q;

  packet_request_tracker #(
    .SAMPLE_CNT_WIDTH (SAMPLE_CNT_WIDTH)
  ) u_tracker (
    .clk_pixel          (clk_pixel),
    .reset_n            (reset_n),
    .acr_toggle         (acr_toggle),
    .audio_sample_valid (audio_sample_valid),
    .frame_start        (frame_start),
    .consume            (consume),
    .acr_pending        (acr_pending),
    .sample_cnt         (sample_cnt),
    .avi_pending        (avi_pending),
    .aif_pending        (aif_pending),
    .acr_overrun_evt    (acr_overrun_evt),
    .audio_overflow_evt (audio_overflow_evt),
    .infoframe_miss_evt (infoframe_miss_evt)
  );

  assign if_pending = avi_pending || aif_pending;
  assign force_if   = (burst_q == BURST_LIMIT) && if_pending;

  always_comb begin
    grant_sel = '0;
    type_sel  = PKT_NULL;
    if (acr_pending) begin
      grant_sel[GRANT_ACR] = 1'b1;
      type_sel             = PKT_ACR;
    end else if ((sample_cnt != '0) && !force_if) begin
      grant_sel[GRANT_AUDIO] = 1'b1;
      type_sel               = PKT_AUDIO_SAMPLE;
    end else if (avi_pending) begin
      grant_sel[GRANT_AVI] = 1'b1;
      type_sel             = PKT_AVI_INFOFRAME;
    end else if (aif_pending) begin
      grant_sel[GRANT_AIF] = 1'b1;
      type_sel             = PKT_AUDIO_INFOFRAME;
    end
  end

  assign consume = packet_slot ? grant_sel : '0;

  // The burst count only measures how long audio has held off a waiting InfoFrame.
  always_comb begin
    burst_d = burst_q;
    if (!if_pending) begin
      burst_d = '0;
    end else if (packet_slot) begin
      if (!grant_sel[GRANT_AUDIO])    burst_d = '0;
      else if (burst_q != BURST_LIMIT) burst_d = burst_q + 1'b1;
    end
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      burst_q          <= '0;
      packet_valid_q   <= 1'b0;
      packet_type_q    <= PKT_NULL;
      packet_grant_q   <= '0;
      acr_overrun_q    <= 1'b0;
      audio_overflow_q <= 1'b0;
      infoframe_miss_q <= 1'b0;
    end else begin
      burst_q        <= burst_d;
      packet_valid_q <= packet_slot;
      packet_grant_q <= consume;
      if (packet_slot) packet_type_q <= type_sel;
      // A status event in the clearing cycle still lands.
      acr_overrun_q    <= acr_overrun_evt    || (acr_overrun_q    && !clear_status);
      audio_overflow_q <= audio_overflow_evt || (audio_overflow_q && !clear_status);
      infoframe_miss_q <= infoframe_miss_evt || (infoframe_miss_q && !clear_status);
    end
  end

  assign packet_valid   = packet_valid_q;
  assign packet_type    = packet_type_q;
  assign packet_grant   = packet_grant_q;
  assign acr_overrun    = acr_overrun_q;
  assign audio_overflow = audio_overflow_q;
  assign infoframe_miss = infoframe_miss_q;

endmodule

// File: tb/tb_data_island_packet_scheduler.sv
// Directed bench for data_island_packet_scheduler: per-cycle vector table plus
// hand-written sequences for the ACR, audio-saturation, burst-override and reset cases.
module tb_data_island_packet_scheduler;

  logic       clk_pixel = 1'b0;
  logic       reset_n;
  logic       packet_slot, acr_toggle, audio_sample_valid, frame_start, clear_status;
  logic       packet_valid;
  logic [7:0] packet_type;
  logic [3:0] packet_grant;
  logic       acr_overrun, audio_overflow, infoframe_miss;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic       slot;
    logic       flip;
    logic       smp;
    logic       fs;
    logic       clr;
    logic       exp_valid;
    logic [7:0] exp_type;
    logic [3:0] exp_grant;
    logic [2:0] exp_status;  // {acr_overrun, audio_overflow, infoframe_miss}
  } vec_t;

  vec_t tbl[25];

  data_island_packet_scheduler #(
    .SAMPLE_CNT_WIDTH (3),
    .AUDIO_BURST_MAX  (4)
  ) dut (
    .clk_pixel          (clk_pixel),
    .reset_n            (reset_n),
    .packet_slot        (packet_slot),
    .acr_toggle         (acr_toggle),
    .audio_sample_valid (audio_sample_valid),
    .frame_start        (frame_start),
    .clear_status       (clear_status),
    .packet_valid       (packet_valid),
    .packet_type        (packet_type),
    .packet_grant       (packet_grant),
    .acr_overrun        (acr_overrun),
    .audio_overflow     (audio_overflow),
    .infoframe_miss     (infoframe_miss)
  );

  always #5 clk_pixel = ~clk_pixel;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input logic v, input logic [7:0] t,
                           input logic [3:0] g, input logic [2:0] s);
    check({name, ".valid"},  32'(packet_valid), 32'(v));
    check({name, ".type"},   32'(packet_type),  32'(t));
    check({name, ".grant"},  32'(packet_grant), 32'(g));
    check({name, ".status"}, 32'({acr_overrun, audio_overflow, infoframe_miss}), 32'(s));
  endtask

  // Drives one cycle of inputs at the falling edge; outputs are sampled 1 time unit
  // after the following rising edge, once the task returns.
  task automatic cycle(input logic slot, input logic flip, input logic smp,
                       input logic fs, input logic clr);
    @(negedge clk_pixel);
    packet_slot        = slot;
    audio_sample_valid = smp;
    frame_start        = fs;
    clear_status       = clr;
    if (flip) acr_toggle = ~acr_toggle;
    @(posedge clk_pixel);
    #1;
    packet_slot        = 1'b0;
    audio_sample_valid = 1'b0;
    frame_start        = 1'b0;
    clear_status       = 1'b0;
  endtask

  logic [7:0] c_type  [9];
  logic [3:0] c_grant [9];

  initial begin
    //          slot flip smp fs clr | valid type  grant    status
    tbl[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'b0000, 3'b000};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'b0000, 3'b000};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 4'b0001, 3'b000};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h02, 4'b0010, 3'b000};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h02, 4'b0000, 3'b000};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 4'b0001, 3'b000};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 4'b0001, 3'b000};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 4'b0000, 3'b000};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 4'b0000, 3'b100};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h01, 4'b0000, 3'b000};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 4'b0001, 3'b000};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h01, 4'b0000, 3'b000};
    tbl[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h02, 4'b0010, 3'b000};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h02, 4'b0010, 3'b000};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 4'b0000, 3'b000};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 4'b0000, 3'b000};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 4'b0000, 3'b001};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 4'b0000, 3'b000};
    tbl[18] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 4'b0000, 3'b001};
    tbl[19] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h82, 4'b0100, 3'b001};
    tbl[20] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h84, 4'b1000, 3'b001};
    tbl[21] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h84, 4'b0000, 3'b000};
    tbl[22] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h82, 4'b0100, 3'b000};
    tbl[23] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h84, 4'b1000, 3'b000};
    tbl[24] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 4'b0000, 3'b000};

    c_type  = '{8'h02, 8'h02, 8'h02, 8'h02, 8'h82, 8'h02, 8'h02, 8'h84, 8'h00};
    c_grant = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0100,
                4'b0010, 4'b0010, 4'b1000, 4'b0000};

    reset_n            = 1'b0;
    packet_slot        = 1'b0;
    acr_toggle         = 1'b0;
    audio_sample_valid = 1'b0;
    frame_start        = 1'b0;
    clear_status       = 1'b0;
    repeat (3) @(posedge clk_pixel);
    #1;
    check_out("reset", 1'b0, 8'h00, 4'b0000, 3'b000);
    @(negedge clk_pixel);
    reset_n = 1'b1;

    // Three ACR requests, 40 cycles apart, each served by a slot 10 cycles later.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      repeat (9) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      check_out($sformatf("acr_grant%0d", i), 1'b1, 8'h01, 4'b0001, 3'b000);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check_out($sformatf("acr_hold%0d", i), 1'b0, 8'h01, 4'b0000, 3'b000);
      repeat (28) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Nine samples saturate a 3-bit counter; overflow flags on the 8th.
    for (int i = 1; i <= 9; i++) begin
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      check($sformatf("overflow_after_pulse%0d", i), 32'(audio_overflow), 32'(i >= 8));
    end
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      if (i < 7) check_out($sformatf("drain%0d", i), 1'b1, 8'h02, 4'b0010, 3'b010);
      else       check_out("drain_null", 1'b1, 8'h00, 4'b0000, 3'b010);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_out("clear_overflow", 1'b0, 8'h00, 4'b0000, 3'b000);

    // Audio burst limit forces the waiting AVI, then AIF after the next run.
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (6) cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      check_out($sformatf("burst%0d", i), 1'b1, c_type[i], c_grant[i], 3'b000);
    end

    // Priority, coincident-event and sticky-status vectors.
    for (int i = 0; i < 25; i++) begin
      cycle(tbl[i].slot, tbl[i].flip, tbl[i].smp, tbl[i].fs, tbl[i].clr);
      check_out($sformatf("vec%0d", i), tbl[i].exp_valid, tbl[i].exp_type,
                tbl[i].exp_grant, tbl[i].exp_status);
    end

    // Load every request and status bit, then reset mid-run.
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_out("pre_reset", 1'b1, 8'h01, 4'b0001, 3'b101);
    #1;
    reset_n    = 1'b0;
    acr_toggle = 1'b0;
    #1;
    check_out("async_reset", 1'b0, 8'h00, 4'b0000, 3'b000);
    repeat (2) @(posedge clk_pixel);
    @(negedge clk_pixel);
    reset_n = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_out("post_reset_idle", 1'b0, 8'h00, 4'b0000, 3'b000);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_out("post_reset_null", 1'b1, 8'h00, 4'b0000, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
